vrased_reset_seq: RTL and testbench
===================================

# vrased_reset_seq

Reset sequencer downstream of the VRASED hardware monitors (stack/data-access monitor and peers). Each monitor's `reset` output lands on one bit of `viol_req`. The block turns any violation into a clean, minimum-width CPU reset request held until the core re-enters its reset handler. It also keeps a sticky per-source cause register and an optional saturating violation counter for post-mortem attestation.

## Interface
- `NUM_SRC`, 4: number of monitor violation inputs.
- `HOLD_CYCLES`, 8: minimum cycles `puc_req` stays high in ASSERT; legal range 1..255.
- `CNT_WIDTH`, 8: width of `viol_cnt`.
- `RESET_HANDLER`, 16'hFFFE: PC value that permits release.
- `clk` in 1: single system clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `pc` in 16: current CPU program counter.
- `viol_req` in NUM_SRC: level violation requests from monitors; bit i = source i.
- `clr_cause` in 1: single-cycle request to clear `cause` and `viol_cnt`.
- `puc_req` out 1: reset request to the CPU.
- `cause` out NUM_SRC: sticky OR of every source seen since the last clear.
- `viol_cnt` out CNT_WIDTH: number of violation episodes, saturating.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- States: IDLE, ASSERT, WAIT_RH.
- IDLE: `puc_req`=0.
  - Any `viol_req` bit high: go to ASSERT; load hold counter with HOLD_CYCLES-1; `cause |= viol_req`; `viol_cnt` +1.
- ASSERT: `puc_req`=1; hold counter decrements each cycle; counter==0 -> WAIT_RH.
- WAIT_RH: `puc_req`=1.
  - `pc==RESET_HANDLER` and `viol_req==0` in the same cycle -> IDLE.
  - Otherwise stay.
- In ASSERT and WAIT_RH, `viol_req` bits still OR into `cause`. No increment: one episode counts once.
- A violation present on the cycle of leaving WAIT_RH blocks the exit; the block stays in WAIT_RH.
- `viol_cnt` saturates at all-ones; it never wraps.
- `clr_cause` acts only in IDLE; ignored in ASSERT/WAIT_RH.
  - Simultaneous with a new violation in IDLE: clear first, then set. Result `cause=viol_req`, `viol_cnt=1`, go to ASSERT.
- `busy` = (state != IDLE).

## Timing
- All outputs registered.
- Reset (`reset_n` low at a rising edge): state IDLE, `puc_req`=0, `cause`=0, `viol_cnt`=0, `busy`=0, hold counter 0. Reset overrides every other input, mid-episode included.
- Latency: `viol_req` high at edge N -> `puc_req`/`busy` high after edge N.
- `puc_req` minimum high time is HOLD_CYCLES cycles in ASSERT plus at least 1 cycle in WAIT_RH.
- Release: exit condition true at edge M -> `puc_req`=0 after edge M.
- Earliest re-trigger: a violation at edge M+1 re-enters ASSERT, giving back-to-back episodes with one low cycle between them.
- `cause` and `viol_cnt` update on the same edge as the state transition.
- HOLD_CYCLES=1: ASSERT lasts exactly one cycle.

## Configuration
- `VRASED_VIOL_CNT_EN` defined: counter register and saturation logic built as described.
- Undefined:
  - `viol_cnt` is a constant 0 with no flops.
  - `clr_cause` clears `cause` only.
  - All other behaviour is identical.

## Test plan
- Reset, then `viol_req`=4'b0010 for 1 cycle:
  - `puc_req` high for 8 cycles in ASSERT, then stays high in WAIT_RH.
  - `cause`=4'b0010, `viol_cnt`=1.
- During WAIT_RH, hold `pc`=16'h1234, then set `pc`=16'hFFFE with `viol_req`=0:
  - `puc_req` falls the cycle after `pc` matches.
  - `busy`=0, `cause` stays 4'b0010.
- In ASSERT, pulse `viol_req`=4'b1000: `cause`=4'b1010, `viol_cnt` stays 1.
- In WAIT_RH, `pc`=16'hFFFE with `viol_req`=4'b0001: stays in WAIT_RH, `cause` gains bit 0. Drop `viol_req` -> release next edge.
- 300 separated episodes with CNT_WIDTH=8: `viol_cnt`=255. Then IDLE `clr_cause` together with `viol_req`=4'b0100: `cause`=4'b0100, `viol_cnt`=1.
- Assert `reset_n` low in the 3rd ASSERT cycle: all outputs 0 after that edge. Repeat the first scenario with `VRASED_VIOL_CNT_EN` undefined: `viol_cnt`=0 throughout.

Source files
------------

// File: rtl/vrased_reset_seq.sv
// vrased_reset_seq: reset sequencer behind the VRASED hardware monitors.
//
// Any monitor violation becomes a CPU reset request (puc_req). The request
// stays high for at least HOLD_CYCLES cycles, and then until the core
// reaches its reset handler with no violation pending. A sticky per-source
// cause register and an optional saturating episode counter are kept for
// post-mortem attestation.
//
// Build option: define VRASED_VIOL_CNT_EN to build the viol_cnt register.
// Without it, viol_cnt is tied to zero and clr_cause clears cause only.
//
// Ports:
//   clk       in            system clock, rising edge
//   reset_n   in            synchronous active-low reset
//   pc        in  [15:0]    CPU program counter
//   viol_req  in  [NUM_SRC] level violation requests, one bit per monitor
//   clr_cause in            clears cause (and viol_cnt); honoured in IDLE only
//   puc_req   out           reset request to the CPU
//   cause     out [NUM_SRC] sticky OR of all sources seen since last clear
//   viol_cnt  out [CNT_W]   saturating count of violation episodes
//   busy      out           high whenever the sequencer is not IDLE
module vrased_reset_seq #(
  parameter int unsigned NUM_SRC       = 4,
  parameter int unsigned HOLD_CYCLES   = 8,
  parameter int unsigned CNT_WIDTH     = 8,
  parameter logic [15:0] RESET_HANDLER = 16'hFFFE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [15:0]          pc,
  input  logic [NUM_SRC-1:0]   viol_req,
  input  logic                 clr_cause,
  output logic                 puc_req,
  output logic [NUM_SRC-1:0]   cause,
  output logic [CNT_WIDTH-1:0] viol_cnt,
  output logic                 busy
);

  localparam int unsigned HOLD_W = 8;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_WAIT_RH = 2'd2
  } state_e;

  state_e              state_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [NUM_SRC-1:0]  cause_q;
  logic [NUM_SRC-1:0]  cause_d;
  logic                puc_q;
  logic                busy_q;
  logic                any_viol_c;
  logic                clr_act_c;

  // A clear only takes effect in IDLE; it is applied before new sources OR in.
  assign any_viol_c = |viol_req;
  assign clr_act_c  = (state_q == S_IDLE) && clr_cause;
  assign cause_d    = (clr_act_c ? '0 : cause_q) | viol_req;

`ifdef VRASED_VIOL_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_base_d;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Saturating increment on top of the (possibly cleared) count.
  assign cnt_base_d = clr_act_c ? '0 : cnt_q;
  assign cnt_d      = (&cnt_base_d) ? cnt_base_d : cnt_base_d + CNT_WIDTH'(1);
  assign viol_cnt   = cnt_q;
`else
  assign viol_cnt   = '0;
`endif

  // Sequencer state, hold timer, cause/counter bookkeeping and outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      cause_q <= '0;
      puc_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef VRASED_VIOL_CNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      // Sources keep accumulating in every state; IDLE may also clear.
      cause_q <= cause_d;
      case (state_q)
        S_IDLE: begin
          if (any_viol_c) begin
            state_q <= S_ASSERT;
            hold_q  <= HOLD_INIT;
            puc_q   <= 1'b1;
            busy_q  <= 1'b1;
`ifdef VRASED_VIOL_CNT_EN
            cnt_q   <= cnt_d;
          end else if (clr_act_c) begin
            cnt_q   <= '0;
`endif
          end
        end
        S_ASSERT: begin
          if (hold_q == '0) begin
            state_q <= S_WAIT_RH;
          end else begin
            hold_q  <= hold_q - HOLD_W'(1);
          end
        end
        S_WAIT_RH: begin
          // Release only at the handler with no violation still pending.
          if ((pc == RESET_HANDLER) && !any_viol_c) begin
            state_q <= S_IDLE;
            puc_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          puc_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign puc_req = puc_q;
  assign busy    = busy_q;
  assign cause   = cause_q;

endmodule

// File: tb/tb_vrased_reset_seq.sv
// Directed bench for vrased_reset_seq (defaults: 4 sources, hold 8, 8-bit count).
module tb_vrased_reset_seq;

`ifdef VRASED_VIOL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [15:0] pc;
  logic [3:0]  viol_req;
  logic        clr_cause;
  logic        puc_req;
  logic [3:0]  cause;
  logic [7:0]  viol_cnt;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  vrased_reset_seq dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pc        (pc),
    .viol_req  (viol_req),
    .clr_cause (clr_cause),
    .puc_req   (puc_req),
    .cause     (cause),
    .viol_cnt  (viol_cnt),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ecnt(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  // Trigger with src for one cycle, handler PC present; back to IDLE after 10 edges.
  task automatic run_episode(input logic [3:0] src);
    viol_req = src;
    pc       = 16'hFFFE;
    tick();
    viol_req = 4'b0000;
    repeat (9) tick();
  endtask

  initial begin
    reset_n   = 1'b0;
    pc        = 16'h0000;
    viol_req  = 4'b0000;
    clr_cause = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("rst_puc",   32'(puc_req),  32'd0);
    check("rst_busy",  32'(busy),     32'd0);
    check("rst_cause", 32'(cause),    32'd0);
    check("rst_cnt",   32'(viol_cnt), 32'd0);

    // Episode 1: source 1, ASSERT pulse of source 3, handler PC during ASSERT.
    viol_req = 4'b0010;
    pc       = 16'h1234;
    tick();                                   // edge N
    viol_req = 4'b0000;
    check("e1_puc",   32'(puc_req),  32'd1);
    check("e1_busy",  32'(busy),     32'd1);
    check("e1_cause", 32'(cause),    32'b0010);
    check("e1_cnt",   32'(viol_cnt), ecnt(1));
    tick();                                   // N+1
    tick();                                   // N+2
    viol_req = 4'b1000;
    tick();                                   // N+3
    viol_req = 4'b0000;
    check("e1_assert_or_cause", 32'(cause),    32'b1010);
    check("e1_assert_no_inc",   32'(viol_cnt), ecnt(1));
    pc = 16'hFFFE;                            // must not release during ASSERT
    repeat (4) tick();                        // N+7, last ASSERT cycle
    check("e1_hold_last", 32'(puc_req), 32'd1);
    tick();                                   // N+8 -> WAIT_RH
    check("e1_wait_puc", 32'(puc_req), 32'd1);
    tick();                                   // N+9 release
    check("e1_rel_puc",   32'(puc_req), 32'd0);
    check("e1_rel_busy",  32'(busy),    32'd0);
    check("e1_rel_cause", 32'(cause),   32'b1010);

    // Episode 2: back-to-back re-trigger; PC away from handler, then blocked exit.
    viol_req = 4'b0100;
    pc       = 16'h1234;
    tick();                                   // M+1
    viol_req = 4'b0000;
    check("e2_retrig_puc", 32'(puc_req),  32'd1);
    check("e2_cause",      32'(cause),    32'b1110);
    check("e2_cnt",        32'(viol_cnt), ecnt(2));
    repeat (11) tick();                       // well inside WAIT_RH
    check("e2_wait_pc_mismatch", 32'(puc_req), 32'd1);
    pc       = 16'hFFFE;
    viol_req = 4'b0001;
    tick();
    check("e2_blocked_puc",   32'(puc_req),  32'd1);
    check("e2_blocked_cause", 32'(cause),    32'b1111);
    check("e2_blocked_cnt",   32'(viol_cnt), ecnt(2));
    viol_req = 4'b0000;
    tick();
    check("e2_rel_puc", 32'(puc_req), 32'd0);

    // Episode 3: clr_cause during ASSERT is ignored.
    viol_req = 4'b0010;
    tick();
    viol_req  = 4'b0000;
    clr_cause = 1'b1;
    tick();
    clr_cause = 1'b0;
    check("e3_clr_ignored_cause", 32'(cause),    32'b1111);
    check("e3_clr_ignored_cnt",   32'(viol_cnt), ecnt(3));
    repeat (8) tick();
    check("e3_rel_puc", 32'(puc_req), 32'd0);

    // Clear in IDLE.
    clr_cause = 1'b1;
    tick();
    clr_cause = 1'b0;
    check("idle_clr_cause", 32'(cause),    32'd0);
    check("idle_clr_cnt",   32'(viol_cnt), 32'd0);
    check("idle_clr_busy",  32'(busy),     32'd0);

    // 300 episodes: counter saturates at 255.
    for (int i = 0; i < 300; i++) run_episode(4'b0001);
    check("sat_cnt",   32'(viol_cnt), ecnt(255));
    check("sat_cause", 32'(cause),    32'b0001);
    check("sat_idle",  32'(puc_req),  32'd0);

    // Clear and new violation together: clear first, then set.
    clr_cause = 1'b1;
    viol_req  = 4'b0100;
    tick();                                   // entry edge, 1st ASSERT cycle
    clr_cause = 1'b0;
    viol_req  = 4'b0000;
    check("clrset_cause", 32'(cause),    32'b0100);
    check("clrset_cnt",   32'(viol_cnt), ecnt(1));
    check("clrset_puc",   32'(puc_req),  32'd1);

    // Reset in the 3rd ASSERT cycle, with a violation also present.
    tick();                                   // 2nd ASSERT cycle
    tick();                                   // 3rd ASSERT cycle
    reset_n  = 1'b0;
    viol_req = 4'b1111;
    tick();
    check("midrst_puc",   32'(puc_req),  32'd0);
    check("midrst_busy",  32'(busy),     32'd0);
    check("midrst_cause", 32'(cause),    32'd0);
    check("midrst_cnt",   32'(viol_cnt), 32'd0);
    reset_n  = 1'b1;
    viol_req = 4'b0000;
    tick();
    check("postrst_idle", 32'(puc_req), 32'd0);

    // After reset the hold timer restarts from scratch.
    run_episode(4'b1000);
    check("post_ep_idle",  32'(busy),     32'd0);
    check("post_ep_cause", 32'(cause),    32'b1000);
    check("post_ep_cnt",   32'(viol_cnt), ecnt(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
